// File: rtl/ram_stream_ctrl_pkg.sv
// Shared constants and helpers for the RAM stream controller and its output buffer.
package ram_stream_ctrl_pkg;

  localparam int OBUF_DEPTH = 3;
  localparam int OBUF_PTR_W = 2;

  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

  // Circular pointer step for the non-power-of-two output buffer.
  function automatic logic [OBUF_PTR_W-1:0] obuf_next_ptr(input logic [OBUF_PTR_W-1:0] ptr);
    return (ptr == OBUF_PTR_W'(OBUF_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

endpackage

// File: rtl/ram_stream_obuf.sv
// Three-entry circular FIFO that absorbs the RAM read latency; push and pop may coincide.
module ram_stream_obuf
  import ram_stream_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic [OBUF_PTR_W-1:0] occ_o
);

  logic [DATA_WIDTH-1:0] mem_q [OBUF_DEPTH];
  logic [OBUF_PTR_W-1:0] wr_ptr_q, rd_ptr_q, occ_q, occ_d;

  always_comb begin
    occ_d = occ_q;
    case ({push_i, pop_i})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= obuf_next_ptr(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= obuf_next_ptr(rd_ptr_q);
      occ_q <= occ_d;
    end
  end

  // NOTE: storage is left unreset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign occ_o      = occ_q;

endmodule

// File: rtl/ram_stream_ctrl.sv
// Stream-side controller for a pointer-addressed RAM with a 1-cycle registered read:
// tracks occupancy, issues credit-limited reads and buffers the results for the consumer.
module ram_stream_ctrl
  import ram_stream_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DATA_WIDTH-1:0]               in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [DATA_WIDTH-1:0]               out_data,
  output logic                                ram_wr_req,
  output logic [DATA_WIDTH-1:0]               ram_wr_data,
  output logic                                ram_rd_req,
  input  logic [DATA_WIDTH-1:0]               ram_rd_data,
  output logic [count_width(ADDR_WIDTH)-1:0]  count,
  output logic                                full,
  output logic                                empty
);

  localparam int CW = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [CW-1:0]         count_q, count_d;
  logic                  inflight_q;
  logic [OBUF_PTR_W-1:0] obuf_occ;
  logic [2:0]            credit;
  logic                  obuf_pop;

  assign full        = (count_q == CAP);
  assign in_ready    = !full;
  assign ram_wr_req  = in_valid & in_ready;
  assign ram_wr_data = in_data;

  // Reads only when the result has a guaranteed slot; no path from out_ready.
  assign credit     = 3'(OBUF_DEPTH) - {1'b0, obuf_occ} - {2'b0, inflight_q};
  assign ram_rd_req = (count_q != '0) & (credit != '0) & reset;

  always_comb begin
    count_d = count_q;
    case ({ram_wr_req, ram_rd_req})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      inflight_q <= ram_rd_req;
    end
  end

  assign out_valid = (obuf_occ != '0);
  assign obuf_pop  = out_valid & out_ready;

  ram_stream_obuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_obuf (
    .clk         (clk),
    .reset       (reset),
    .push_i      (inflight_q),
    .push_data_i (ram_rd_data),
    .pop_i       (obuf_pop),
    .pop_data_o  (out_data),
    .occ_o       (obuf_occ)
  );

  assign count = count_q;
  assign empty = (count_q == '0) & (obuf_occ == '0) & !inflight_q;

endmodule
